// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - instruction prefetch queue with single outstanding RAM read
//
// Purpose: fetches instruction words from a synchronous instruction RAM into a
// DEPTH-entry FIFO of {instruction, byte PC} pairs, stopping once the
// end-of-program word has been queued and restarting on a redirect.
//
// Ports:
//   CLOCK_50     in   system clock, all state on rising edge
//   rstn         in   synchronous active-low reset
//   imem_rd_en   out  instruction RAM read request
//   imem_addr    out  instruction RAM word address (byte PC >> 2)
//   imem_data    in   RAM read data, valid the cycle after imem_rd_en
//   instr_valid  out  head entry available to decode
//   instr_ready  in   decode accepts head entry
//   instr_out    out  head instruction word
//   instr_pc     out  byte PC of head instruction
//   redirect     in   taken branch/jump: flush and refetch
//   redirect_pc  in   new byte PC, bits [1:0] ignored
//   eof_seen     out  head entry equals EOF_WORD
//   fetch_count  out  words pushed into the FIFO since reset

module instr_fetch_queue #(
  parameter int          DEPTH      = 4,
  parameter int          IMEM_WORDS = 35,
  parameter logic [31:0] EOF_WORD   = 32'hFFFF_FFFF
) (
  input  logic        CLOCK_50,
  input  logic        rstn,
  output logic        imem_rd_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        eof_seen,
  output logic [31:0] fetch_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc;

  // Stage 1: request presented to the RAM this cycle.
  // Stage 2: RAM data returning this cycle, pushed at the next edge.
  // The *_syn flag marks an out-of-range fetch that never touches the RAM
  // and is replaced by EOF_WORD when it reaches the push stage.
  logic        s1_v, s1_syn;
  logic [31:0] s1_pc;
  logic        s2_v, s2_syn;
  logic [31:0] s2_pc;

  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic        push, pop, push_eof, room, issue, in_range;
  logic [31:0] push_word;

  assign push      = s2_v;
  assign push_word = s2_syn ? EOF_WORD : imem_data;
  assign push_eof  = push && (push_word == EOF_WORD);
  assign pop       = instr_valid && instr_ready;

  // The word currently returning still needs a slot, so it counts against room.
  assign room      = (count + CW'(s2_v)) < CW'(DEPTH);
  assign in_range  = (fetch_pc >> 2) < 32'(IMEM_WORDS);

  assign imem_rd_en  = s1_v && !s1_syn;
  assign imem_addr   = s1_pc >> 2;
  assign instr_valid = (count != '0);
  assign instr_out   = fifo_instr[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];
  assign eof_seen    = instr_valid && (fifo_instr[rd_ptr] == EOF_WORD);

  // Next-state and issue decision. Issue is blocked while a request is on the
  // RAM port (single outstanding read) and on the edge that queues EOF, so
  // nothing is fetched past the end of the program.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    if (redirect) begin
      state_d = RUN;
    end else begin
      if (state_q == RUN && !s1_v && room && !push_eof)
        issue = 1'b1;
      if (push_eof)
        state_d = HALT;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rstn) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rstn) begin
      fetch_pc    <= '0;
      s1_v        <= 1'b0;
      s1_syn      <= 1'b0;
      s1_pc       <= '0;
      s2_v        <= 1'b0;
      s2_syn      <= 1'b0;
      s2_pc       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      fetch_count <= '0;
    end else if (redirect) begin
      // Any returning RAM word is dropped by clearing the pipeline valids.
      fetch_pc <= redirect_pc & ~32'h3;
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      s1_v   <= issue;
      s1_syn <= issue && !in_range;
      if (issue) begin
        s1_pc    <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      s2_v   <= s1_v;
      s2_syn <= s1_syn;
      s2_pc  <= s1_pc;
      if (push) begin
        wr_ptr      <= wr_ptr + 1'b1;
        fetch_count <= fetch_count + 32'd1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rstn && !redirect && push) begin
      fifo_instr[wr_ptr] <= push_word;
      fifo_pc[wr_ptr]    <= s2_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - scoreboard bench for instr_fetch_queue

module tb_instr_fetch_queue;

  localparam int          IMEM_WORDS = 35;
  localparam logic [31:0] EOFW       = 32'hFFFF_FFFF;

  logic        CLOCK_50 = 1'b0;
  logic        rstn;
  logic        imem_rd_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        eof_seen;
  logic [31:0] fetch_count;

  instr_fetch_queue #(.DEPTH(4), .IMEM_WORDS(IMEM_WORDS), .EOF_WORD(EOFW)) dut (
    .CLOCK_50    (CLOCK_50),
    .rstn        (rstn),
    .imem_rd_en  (imem_rd_en),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .eof_seen    (eof_seen),
    .fetch_count (fetch_count)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  logic [31:0] ram [0:63];
  always @(posedge CLOCK_50)
    if (imem_rd_en) imem_data <= ram[imem_addr[5:0]];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   issue_cnt = 0;
  int   bad_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted head entry.
  always @(negedge CLOCK_50) begin
    if (rstn && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop actual=%h@%h required=none", instr_out, instr_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("instr_out", instr_out, mon_e.instr);
        chk("instr_pc", instr_pc, mon_e.pc);
        chk("eof_seen", 32'(eof_seen), 32'(mon_e.instr == EOFW));
      end
    end
    if (imem_rd_en) begin
      issue_cnt++;
      if (imem_addr >= 32'(IMEM_WORDS)) bad_cnt++;
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic expect_word(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  task automatic expect_prog_a();
    expect_word(32'hA000_0000, 32'd0);
    expect_word(32'hA000_0001, 32'd4);
    expect_word(32'hA000_0002, 32'd8);
    expect_word(EOFW,          32'd12);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_count(input logic [31:0] target);
    int n = 0;
    while (fetch_count != target && n < 100) begin
      tick();
      n++;
    end
    chk("fetch_count_reach", fetch_count, target);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    tick();
    redirect    = 1'b0;
  endtask

  int  base_iss;
  int  base_bad;
  int  n;
  logic found;

  initial begin
    rstn        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    for (int i = 0; i < 64; i++) ram[i] = 32'hBAD0_0000 + i;
    ram[0]  = 32'hA000_0000; ram[1]  = 32'hA000_0001; ram[2]  = 32'hA000_0002; ram[3]  = EOFW;
    ram[4]  = 32'hE000_0000; ram[5]  = 32'hE000_0001; ram[6]  = 32'hE000_0002; ram[7]  = EOFW;
    for (int i = 0; i < 5; i++) ram[16+i] = 32'hD000_0000 + i;
    ram[21] = EOFW;
    ram[34] = 32'hF000_0034;

    // Reset state
    repeat (3) tick();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_rd_en", 32'(imem_rd_en), 32'd0);
    chk("rst_eof", 32'(eof_seen), 32'd0);
    chk("rst_count", fetch_count, 32'd0);

    // A,B,C,EOF from reset; first valid three edges after release
    expect_prog_a();
    instr_ready = 1'b1;
    base_iss = issue_cnt;
    rstn = 1'b1;
    tick();
    chk("first_rd_en", 32'(imem_rd_en), 32'd1);
    chk("first_addr", imem_addr, 32'd0);
    chk("lat_valid1", 32'(instr_valid), 32'd0);
    tick();
    chk("lat_valid2", 32'(instr_valid), 32'd0);
    tick();
    chk("lat_valid3", 32'(instr_valid), 32'd1);
    wait_drain();
    repeat (4) tick();
    chk("s1_issues", 32'(issue_cnt - base_iss), 32'd4);
    chk("s1_count", fetch_count, 32'd4);
    chk("s1_halt_rd", 32'(imem_rd_en), 32'd0);
    chk("s1_empty", 32'(instr_valid), 32'd0);

    // Back-pressure: exactly DEPTH issues, then in-order drain
    instr_ready = 1'b0;
    base_iss = issue_cnt;
    do_redirect(32'h40);
    repeat (20) tick();
    chk("bp_issues", 32'(issue_cnt - base_iss), 32'd4);
    chk("bp_valid", 32'(instr_valid), 32'd1);
    chk("bp_count", fetch_count, 32'd8);
    for (int i = 0; i < 5; i++) expect_word(32'hD000_0000 + i, 32'h40 + 4*i);
    expect_word(EOFW, 32'h54);
    instr_ready = 1'b1;
    wait_drain();
    repeat (3) tick();
    chk("bp_count_end", fetch_count, 32'd10);

    // Redirect with FIFO holding 3 and the 4th read in flight
    instr_ready = 1'b0;
    do_redirect(32'h20);
    found = 1'b0;
    n = 0;
    while (!found && n < 40) begin
      tick();
      n++;
      if (imem_rd_en && imem_addr == 32'd11) found = 1'b1;
    end
    chk("rd_addr11_seen", 32'(found), 32'd1);
    do_redirect(32'h13);
    chk("flush_valid", 32'(instr_valid), 32'd0);
    chk("flush_rd_en", 32'(imem_rd_en), 32'd0);
    chk("flush_count", fetch_count, 32'd13);
    tick();
    chk("refetch_rd_en", 32'(imem_rd_en), 32'd1);
    chk("refetch_addr", imem_addr, 32'd4);
    expect_word(32'hE000_0000, 32'h10);
    expect_word(32'hE000_0001, 32'h14);
    expect_word(32'hE000_0002, 32'h18);
    expect_word(EOFW,          32'h1C);
    instr_ready = 1'b1;
    wait_drain();
    repeat (3) tick();
    chk("flush_count_end", fetch_count, 32'd17);

    // Last valid word then synthesized EOF past IMEM_WORDS
    base_iss = issue_cnt;
    base_bad = bad_cnt;
    expect_word(32'hF000_0034, 32'd136);
    expect_word(EOFW,          32'd140);
    do_redirect(32'd136);
    wait_drain();
    repeat (4) tick();
    chk("oor_bad_reads", 32'(bad_cnt - base_bad), 32'd0);
    chk("oor_issues", 32'(issue_cnt - base_iss), 32'd1);
    chk("oor_count", fetch_count, 32'd19);

    // Simultaneous push and pop with two entries queued
    instr_ready = 1'b0;
    do_redirect(32'h0);
    wait_count(32'd21);
    expect_prog_a();
    instr_ready = 1'b1;
    wait_drain();
    repeat (3) tick();
    chk("pp_count", fetch_count, 32'd23);

    // One-cycle reset with 3 entries queued
    instr_ready = 1'b0;
    do_redirect(32'h40);
    wait_count(32'd26);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("mrst_valid", 32'(instr_valid), 32'd0);
    chk("mrst_count", fetch_count, 32'd0);
    chk("mrst_rd_en", 32'(imem_rd_en), 32'd0);
    tick();
    chk("mrst_rd_en2", 32'(imem_rd_en), 32'd1);
    chk("mrst_addr", imem_addr, 32'd0);
    expect_prog_a();
    instr_ready = 1'b1;
    wait_drain();
    repeat (3) tick();
    chk("mrst_count_end", fetch_count, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
